// File: rtl/sin_req_arbiter.sv
// sin_req_arbiter: shares one pipelined sine interpolation unit among
// NUM_REQ requesters. Each cycle it grants at most one requester, forwards
// that requester's phase to the sine unit, and remembers who asked in a tag
// shift register. When the sine result comes back, it is returned to the
// matching requester with a one-hot valid.
//
// Configuration macro: SIN_REQ_ARBITER_FIXED_PRIO_EN
//   undefined (default) - round-robin grant starting at rr_ptr
//   defined             - fixed priority, lowest valid index wins (no rr_ptr)
module sin_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SIN_LATENCY = 2,
    parameter int ID_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [14*NUM_REQ-1:0]   req_phase,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [13:0]             sin_x,
    input  logic [15:0]             sin_y,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [15:0]             resp_data,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy
);

    logic [NUM_REQ-1:0]     grant_vec;
    logic [ID_W-1:0]        grant_id;
    logic                   transfer;
    int                     cand;

    // One slot per sine-unit pipeline stage; the last slot lines up with sin_y.
    logic [SIN_LATENCY-1:0] tag_valid;
    logic [ID_W-1:0]        tag_id [SIN_LATENCY];

`ifndef SIN_REQ_ARBITER_FIXED_PRIO_EN
    logic [ID_W-1:0]        rr_ptr;
`endif

    // Pick the winning requester; scanning from the far end means the
    // candidate closest to the search start is the one left standing.
    always_comb begin
        grant_vec = '0;
        grant_id  = '0;
        cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef SIN_REQ_ARBITER_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(rr_ptr) + k) % NUM_REQ;
`endif
            if (req_valid[cand]) begin
                grant_vec       = '0;
                grant_vec[cand] = 1'b1;
                grant_id        = ID_W'(cand);
            end
        end
    end

    // Grants are suppressed while issuing is disabled or reset is asserted.
    always_comb begin
        req_ready = '0;
        if (issue_en && !rst) begin
            req_ready = grant_vec;
        end
        transfer = |(req_valid & req_ready);
    end

    // Phase register feeding the sine unit; holds when nothing is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            sin_x <= '0;
        end else if (transfer) begin
            sin_x <= req_phase[14*grant_id +: 14];
        end
    end

`ifndef SIN_REQ_ARBITER_FIXED_PRIO_EN
    // Round-robin pointer moves to the requester just after the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            if (grant_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + 1'b1;
            end
        end
    end
`endif

    // Tag pipe shifts every cycle in lockstep with the sine unit, never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            for (int s = 0; s < SIN_LATENCY; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid[0] <= transfer;
            tag_id[0]    <= grant_id;
            for (int s = 1; s < SIN_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    // Return the sine result to its owner; data and id hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else if (tag_valid[SIN_LATENCY-1]) begin
            resp_valid <= NUM_REQ'(1) << tag_id[SIN_LATENCY-1];
            resp_data  <= sin_y;
            resp_id    <= tag_id[SIN_LATENCY-1];
        end else begin
            resp_valid <= '0;
        end
    end

    // Busy reflects only requests still inside the sine pipeline.
    always_comb begin
        busy = |tag_valid;
    end

endmodule

// File: tb/tb_sin_req_arbiter.sv
// tb_sin_req_arbiter: directed self-checking bench for sin_req_arbiter with
// four requesters and a two-cycle sine unit modelled by a single register
// stage behind sin_x, so its result lines up with the last tag slot.
module tb_sin_req_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int SIN_LATENCY = 2;
    localparam int ID_W        = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  issue_en = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [14*NUM_REQ-1:0] req_phase = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [13:0]           sin_x;
    logic [15:0]           sin_y = '0;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [15:0]           resp_data;
    logic [ID_W-1:0]       resp_id;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    sin_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .SIN_LATENCY(SIN_LATENCY),
        .ID_W       (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .issue_en  (issue_en),
        .req_valid (req_valid),
        .req_phase (req_phase),
        .req_ready (req_ready),
        .sin_x     (sin_x),
        .sin_y     (sin_y),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_id   (resp_id),
        .busy      (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference sine unit: an arbitrary bijective mapping, one register deep.
    function automatic logic [15:0] sin_fn(input logic [13:0] x);
        return {x, 2'b01} ^ 16'h5A3C;
    endfunction

    function automatic logic [3:0] oneHot(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    // Sine unit model driven by the DUT's phase register.
    always @(posedge clk) sin_y <= sin_fn(sin_x);

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [13:0] p0,
                                 input logic [13:0] p1, input logic [13:0] p2,
                                 input logic [13:0] p3, input logic en);
        @(negedge clk);
        req_valid = v;
        req_phase = {p3, p2, p1, p0};
        issue_en  = en;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        issue_en  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_id [10];
        logic [3:0] exp_rdy;

        $display("[TB] start");

        // Reset then idle; ready must stay low while reset is high.
        @(negedge clk);
        rst = 1'b1;
        issue_en = 1'b1;
        req_valid = 4'hF;
        #1;
        checkOutput("ready_in_reset", req_ready, 4'b0000);
        tick();
        tick();
        checkOutput("rst_sin_x", sin_x, 14'h0000);
        checkOutput("rst_resp_valid", resp_valid, 4'b0000);
        checkOutput("rst_resp_data", resp_data, 16'h0000);
        checkOutput("rst_resp_id", resp_id, 2'd0);
        checkOutput("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1;
        checkOutput("idle_ready", req_ready, 4'b0000);
        tick();
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_resp_valid", resp_valid, 4'b0000);

        // Single request from requester 0.
        applyStimulus(4'b0001, 14'h0007, 14'h0, 14'h0, 14'h0, 1'b1);
        checkOutput("single_ready", req_ready, 4'b0001);
        tick();
        checkOutput("single_sin_x", sin_x, 14'h0007);
        checkOutput("single_busy_1", busy, 1'b1);
        checkOutput("single_no_resp_1", resp_valid, 4'b0000);
        applyStimulus(4'b0000, 14'h0, 14'h0, 14'h0, 14'h0, 1'b1);
        checkOutput("single_ready_off", req_ready, 4'b0000);
        tick();
        checkOutput("single_busy_2", busy, 1'b1);
        checkOutput("single_no_resp_2", resp_valid, 4'b0000);
        tick();
        checkOutput("single_resp_valid", resp_valid, 4'b0001);
        checkOutput("single_resp_id", resp_id, 2'd0);
        checkOutput("single_resp_data", resp_data, sin_fn(14'h0007));
        checkOutput("single_busy_3", busy, 1'b0);
        tick();
        checkOutput("single_resp_pulse", resp_valid, 4'b0000);
        checkOutput("single_data_hold", resp_data, sin_fn(14'h0007));

        // All four requesters valid for eight cycles, then drain.
        resetDut();
        for (int c = 0; c < 10; c++) begin
`ifdef SIN_REQ_ARBITER_FIXED_PRIO_EN
            exp_id[c] = 0;
`else
            exp_id[c] = c % 4;
`endif
        end
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                applyStimulus(4'hF, 14'h0100, 14'h0101, 14'h0102, 14'h0103, 1'b1);
                exp_rdy = oneHot(exp_id[c]);
            end else begin
                applyStimulus(4'h0, 14'h0100, 14'h0101, 14'h0102, 14'h0103, 1'b1);
                exp_rdy = 4'b0000;
            end
            checkOutput("rr_ready", req_ready, exp_rdy);
            tick();
            if (c < 8) begin
                checkOutput("rr_sin_x", sin_x, 14'h0100 + 14'(exp_id[c]));
            end
            if (c >= 2) begin
                checkOutput("rr_resp_valid", resp_valid, oneHot(exp_id[c-2]));
                checkOutput("rr_resp_id", resp_id, exp_id[c-2]);
                checkOutput("rr_resp_data", resp_data, sin_fn(14'h0100 + 14'(exp_id[c-2])));
            end else begin
                checkOutput("rr_resp_early", resp_valid, 4'b0000);
            end
            checkOutput("rr_busy", busy, (c <= 8) ? 1'b1 : 1'b0);
        end

        // Two issues, then issuing disabled for three cycles while they drain.
        resetDut();
        applyStimulus(4'b0001, 14'h00AA, 14'h0, 14'h0, 14'h0, 1'b1);
        checkOutput("en_ready_a", req_ready, 4'b0001);
        tick();
        applyStimulus(4'b1000, 14'h0, 14'h0, 14'h0, 14'h3FFF, 1'b1);
        checkOutput("en_ready_b", req_ready, 4'b1000);
        tick();
        checkOutput("en_sin_x_max", sin_x, 14'h3FFF);
        for (int d = 0; d < 3; d++) begin
            applyStimulus(4'b0110, 14'h0, 14'h0111, 14'h0222, 14'h0, 1'b0);
            checkOutput("en_off_ready", req_ready, 4'b0000);
            tick();
            checkOutput("en_off_sin_x_hold", sin_x, 14'h3FFF);
            if (d == 0) begin
                checkOutput("en_off_resp_a", resp_valid, 4'b0001);
                checkOutput("en_off_data_a", resp_data, sin_fn(14'h00AA));
            end else if (d == 1) begin
                checkOutput("en_off_resp_b", resp_valid, 4'b1000);
                checkOutput("en_off_id_b", resp_id, 2'd3);
                checkOutput("en_off_data_b", resp_data, sin_fn(14'h3FFF));
            end else begin
                checkOutput("en_off_resp_none", resp_valid, 4'b0000);
                checkOutput("en_off_busy", busy, 1'b0);
            end
        end
        applyStimulus(4'b0110, 14'h0, 14'h0111, 14'h0222, 14'h0, 1'b1);
        checkOutput("en_on_first", req_ready, 4'b0010);
        tick();
        checkOutput("en_on_sin_x1", sin_x, 14'h0111);
        applyStimulus(4'b0100, 14'h0, 14'h0111, 14'h0222, 14'h0, 1'b1);
        checkOutput("en_on_second", req_ready, 4'b0100);
        tick();
        checkOutput("en_on_sin_x2", sin_x, 14'h0222);
        applyStimulus(4'b0000, 14'h0, 14'h0, 14'h0, 14'h0, 1'b1);
        tick();
        checkOutput("en_on_resp1", resp_valid, 4'b0010);
        checkOutput("en_on_data1", resp_data, sin_fn(14'h0111));
        tick();
        checkOutput("en_on_resp2", resp_valid, 4'b0100);
        checkOutput("en_on_id2", resp_id, 2'd2);

        // Reset with two requests in flight drops both responses.
        resetDut();
        applyStimulus(4'b0100, 14'h0, 14'h0, 14'h0055, 14'h0, 1'b1);
        checkOutput("flush_ready_a", req_ready, 4'b0100);
        tick();
        applyStimulus(4'b0010, 14'h0, 14'h0066, 14'h0, 14'h0, 1'b1);
        checkOutput("flush_ready_b", req_ready, 4'b0010);
        tick();
        checkOutput("flush_busy_pre", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        checkOutput("flush_ready_rst", req_ready, 4'b0000);
        tick();
        checkOutput("flush_busy_post", busy, 1'b0);
        checkOutput("flush_resp_0", resp_valid, 4'b0000);
        checkOutput("flush_sin_x", sin_x, 14'h0000);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("flush_resp_later", resp_valid, 4'b0000);
            checkOutput("flush_busy_later", busy, 1'b0);
        end

        // Requesters 0 and 3 contending for four cycles.
        resetDut();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b1001, 14'h00F0, 14'h0, 14'h0, 14'h030F, 1'b1);
`ifdef SIN_REQ_ARBITER_FIXED_PRIO_EN
            exp_rdy = 4'b0001;
`else
            exp_rdy = (c % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
            checkOutput("contend_ready", req_ready, exp_rdy);
            tick();
            checkOutput("contend_sin_x", sin_x, (exp_rdy == 4'b0001) ? 14'h00F0 : 14'h030F);
        end
        applyStimulus(4'b0000, 14'h0, 14'h0, 14'h0, 14'h0, 1'b1);
        tick();
        tick();
        checkOutput("contend_drain_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
